// File: rtl/alu_op_sequencer_if.sv
// Command, ALU and result bundle between a host, the sequencer and the external
// combinational ALU.
interface alu_op_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic [WIDTH-1:0] alu_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_err;
    logic             busy;

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, res_ready,
        output cmd_ready, alu_op, alu_in1, alu_in2, res_valid, res_data, res_err, busy
    );

    // Host / ALU side.
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, res_ready,
        input  cmd_ready, alu_op, alu_in1, alu_in2, res_valid, res_data, res_err, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Command-level controller for an external combinational ALU. Logic ops, ADD
// and SUB take one EXEC cycle; MUL runs WIDTH shift-add passes through the
// ALU adder; reserved opcodes return an error result immediately.
module alu_op_sequencer #(
    parameter int unsigned WIDTH  = 16,
    parameter bit          MUL_EN = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    alu_op_sequencer_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL_STEP,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;      // operand A, doubles as the shifting multiplicand
    logic [WIDTH-1:0] r_b;      // operand B, doubles as the shifting multiplier
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_data;
    logic             r_err;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_reserved;
    logic             w_is_mul;
    logic             w_last;
    logic [2:0]       w_alu_op;
    logic [WIDTH-1:0] w_alu_in1;
    logic [WIDTH-1:0] w_alu_in2;

    assign w_accept   = (r_state == IDLE) && bus.cmd_valid;
    assign w_is_mul   = (bus.cmd_op == 3'b110) && MUL_EN;
    assign w_reserved = (bus.cmd_op == 3'b111) || ((bus.cmd_op == 3'b110) && !MUL_EN);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.res_valid = (r_state == DONE);
    assign bus.res_data  = r_data;
    assign bus.res_err   = r_err;
    assign bus.alu_op    = w_alu_op;
    assign bus.alu_in1   = w_alu_in1;
    assign bus.alu_in2   = w_alu_in2;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and ALU operand steering; ALU inputs idle at zero.
    always_comb begin
        w_next    = r_state;
        w_alu_op  = 3'b000;
        w_alu_in1 = '0;
        w_alu_in2 = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_reserved) begin
                        w_next = DONE;
                    end else if (w_is_mul) begin
                        w_next = MUL_STEP;
                    end else begin
                        w_next = EXEC;
                    end
                end
            end
            EXEC: begin
                w_alu_op  = r_op;
                w_alu_in1 = r_a;
                w_alu_in2 = r_b;
                w_next    = DONE;
            end
            MUL_STEP: begin
                w_alu_op  = 3'b100;
                w_alu_in1 = r_acc;
                w_alu_in2 = r_b[0] ? r_a : '0;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand latch, multiply iteration and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op   <= 3'b000;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op  <= bus.cmd_op;
                        r_a   <= bus.cmd_a;
                        r_b   <= bus.cmd_b;
                        r_acc <= '0;
                        r_cnt <= '0;
                        if (w_reserved) begin
                            r_data <= '0;
                            r_err  <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    r_data <= bus.alu_out;
                    r_err  <= 1'b0;
                end
                MUL_STEP: begin
                    r_acc <= bus.alu_out;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_data <= bus.alu_out;
                        r_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
